// File: rtl/nonce_pkg.sv
// Shared nonce types and helpers for the dispatcher and the downstream extractor.
package nonce_pkg;

    typedef logic [31:0] nonce_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        SWEEP = 2'd2
    } dispatch_state_t;

    // 33-bit sum so a step past the top of the nonce space is visible as a carry.
    function automatic logic [32:0] next_base(input nonce_t base, input nonce_t step);
        return {1'b0, base} + {1'b0, step};
    endfunction

endpackage

// File: rtl/nonce_step_counter.sv
// Base-nonce accumulator: clear to 0, add STEP on enable, and flag when the
// beat after next would reach or pass 2^NONCE_BITS.
module nonce_step_counter
    import nonce_pkg::*;
#(
    parameter int unsigned STEP       = 10,
    parameter int unsigned NONCE_BITS = 32
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   en,
    output nonce_t base,
    output logic   next_at_limit
);

    localparam logic [32:0] LIMIT  = 33'd1 << NONCE_BITS;
    localparam nonce_t      STEP_C = nonce_t'(STEP);

    nonce_t      base_r;
    logic [32:0] sum_s;
    logic [32:0] sum2_s;

    // Accumulator register; holds its value when neither clear nor enable is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r <= 32'd0;
        end else if (clr) begin
            base_r <= 32'd0;
        end else if (en) begin
            base_r <= sum_s[31:0];
        end
    end

    // sum2 only matters when sum itself is still inside the space, so its low word suffices.
    always_comb begin
        sum_s         = next_base(base_r, STEP_C);
        sum2_s        = next_base(sum_s[31:0], STEP_C);
        next_at_limit = (sum2_s >= LIMIT);
    end

    assign base = base_r;

endmodule

// File: rtl/nonce_dispatcher.sv
// Issue side of the nonce protocol: emits newblock/valid beats of NUMPROCESSORS nonces.
// Optional success abort enabled by defining NONCE_DISPATCHER_SUCCESS_ABORT_EN.
module nonce_dispatcher
    import nonce_pkg::*;
#(
    parameter int unsigned NUMPROCESSORS = 10,
    parameter int unsigned NONCE_BITS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        hold_i,
    input  logic        success_i,
    output logic        valid_o,
    output logic        newblock_o,
    output logic [31:0] nonce_base_o,
    output logic        last_o,
    output logic        busy_o,
    output logic        exhausted_o
);

    localparam logic [32:0] LIMIT         = 33'd1 << NONCE_BITS;
    localparam logic        FIRST_IS_LAST = (33'(NUMPROCESSORS) >= LIMIT);

`ifdef NONCE_DISPATCHER_SUCCESS_ABORT_EN
    localparam logic ABORT_EN = 1'b1;
`else
    localparam logic ABORT_EN = 1'b0;
`endif

    dispatch_state_t state_r, state_s;
    logic valid_r, valid_s;
    logic newblock_r, newblock_s;
    logic last_r, last_s;
    logic busy_r, busy_s;
    logic exhausted_r, exhausted_s;
    logic clr_s, en_s, abort_s;
    logic next_at_limit_s;
    nonce_t base_s;

    nonce_step_counter #(
        .STEP       (NUMPROCESSORS),
        .NONCE_BITS (NONCE_BITS)
    ) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr_s),
        .en            (en_s),
        .base          (base_s),
        .next_at_limit (next_at_limit_s)
    );

    // Next-state and next-beat decision; start has priority over abort and sweep progress.
    always_comb begin
        state_s     = state_r;
        valid_s     = 1'b0;
        newblock_s  = 1'b0;
        last_s      = 1'b0;
        exhausted_s = exhausted_r;
        clr_s       = 1'b0;
        en_s        = 1'b0;
        abort_s     = success_i & ABORT_EN;
        if (start_i) begin
            exhausted_s = 1'b0;
            clr_s       = 1'b1;
            if (hold_i) begin
                state_s = FIRST;
            end else begin
                state_s    = SWEEP;
                valid_s    = 1'b1;
                newblock_s = 1'b1;
                last_s     = FIRST_IS_LAST;
            end
        end else if (abort_s && (state_r != IDLE)) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                FIRST: begin
                    if (!hold_i) begin
                        state_s    = SWEEP;
                        clr_s      = 1'b1;
                        valid_s    = 1'b1;
                        newblock_s = 1'b1;
                        last_s     = FIRST_IS_LAST;
                    end else begin
                        state_s = FIRST;
                    end
                end
                SWEEP: begin
                    // The beat on the outputs was the last one: retire the sweep.
                    if (last_r) begin
                        state_s     = IDLE;
                        exhausted_s = 1'b1;
                    end else if (!hold_i) begin
                        en_s    = 1'b1;
                        valid_s = 1'b1;
                        last_s  = next_at_limit_s;
                    end else begin
                        state_s = SWEEP;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            valid_r     <= 1'b0;
            newblock_r  <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            exhausted_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            valid_r     <= valid_s;
            newblock_r  <= newblock_s;
            last_r      <= last_s;
            busy_r      <= busy_s;
            exhausted_r <= exhausted_s;
        end
    end

    assign valid_o      = valid_r;
    assign newblock_o   = newblock_r;
    assign last_o       = last_r;
    assign busy_o       = busy_r;
    assign exhausted_o  = exhausted_r;
    assign nonce_base_o = base_s;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher: a 6-bit nonce space instance for sweep
// sequencing and a 32-bit instance for the top-of-space boundary.
module tb_nonce_dispatcher;

    logic clk = 1'b0;
    logic rst;
    logic start_i, hold_i, success_i;
    logic valid_o, newblock_o, last_o, busy_o, exhausted_o;
    logic [31:0] nonce_base_o;

    logic start32, hold32;
    logic valid32, newblock32, last32, busy32, exhausted32;
    logic [31:0] base32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nonce_dispatcher #(.NUMPROCESSORS(10), .NONCE_BITS(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .hold_i       (hold_i),
        .success_i    (success_i),
        .valid_o      (valid_o),
        .newblock_o   (newblock_o),
        .nonce_base_o (nonce_base_o),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .exhausted_o  (exhausted_o)
    );

    nonce_dispatcher #(.NUMPROCESSORS(10), .NONCE_BITS(32)) dut32 (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start32),
        .hold_i       (hold32),
        .success_i    (1'b0),
        .valid_o      (valid32),
        .newblock_o   (newblock32),
        .nonce_base_o (base32),
        .last_o       (last32),
        .busy_o       (busy32),
        .exhausted_o  (exhausted32)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flags are packed {valid, newblock, last, busy, exhausted}.
    task automatic expect_out(input string tag, input logic [4:0] flags, input logic [31:0] base,
                              input bit chk_base);
        check_val({tag, " flags"}, 64'({valid_o, newblock_o, last_o, busy_o, exhausted_o}),
                  64'(flags));
        if (chk_base) check_val({tag, " base"}, 64'(nonce_base_o), 64'(base));
    endtask

    task automatic expect32(input string tag, input logic [4:0] flags, input logic [31:0] base);
        check_val({tag, " flags32"}, 64'({valid32, newblock32, last32, busy32, exhausted32}),
                  64'(flags));
        check_val({tag, " base32"}, 64'(base32), 64'(base));
    endtask

    // Expect beats 10*k0 .. 50, then 60 as last, then the exhausted idle cycle.
    task automatic sweep_rest(input string tag, input int k0);
        for (int k = k0; k <= 5; k++) begin
            step();
            expect_out(tag, 5'b10010, 32'(10 * k), 1'b1);
        end
        step();
        expect_out({tag, " last"}, 5'b10110, 32'd60, 1'b1);
        step();
        expect_out({tag, " done"}, 5'b00001, 32'd0, 1'b0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; hold_i = 1'b0; success_i = 1'b0;
        start32 = 1'b0; hold32 = 1'b0;
        step();
        step();
        rst = 1'b0;
        expect_out("reset", 5'b00000, 32'd0, 1'b1);
        step();
        step();
        expect_out("idle", 5'b00000, 32'd0, 1'b1);

        // Plain sweep to exhaustion.
        pulse_start();
        expect_out("t1 newblock", 5'b11010, 32'd0, 1'b1);
        sweep_rest("t1", 1);
        step();
        expect_out("t1 no wrap", 5'b00001, 32'd0, 1'b0);

        // Backpressure for two beat slots; start also clears exhausted.
        pulse_start();
        expect_out("t2 newblock", 5'b11010, 32'd0, 1'b1);
        step();
        expect_out("t2 b10", 5'b10010, 32'd10, 1'b1);
        hold_i = 1'b1;
        step();
        expect_out("t2 hold1", 5'b00010, 32'd10, 1'b1);
        step();
        expect_out("t2 hold2", 5'b00010, 32'd10, 1'b1);
        hold_i = 1'b0;
        sweep_rest("t2", 2);

        // Preempting start while base 30 is on the outputs.
        pulse_start();
        expect_out("t3 newblock", 5'b11010, 32'd0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            expect_out("t3 pre", 5'b10010, 32'(10 * k), 1'b1);
        end
        pulse_start();
        expect_out("t3 restart", 5'b11010, 32'd0, 1'b1);
        sweep_rest("t3", 1);

        // Reset while base 40 is on the outputs.
        pulse_start();
        for (int k = 1; k <= 4; k++) step();
        expect_out("t4 b40", 5'b10010, 32'd40, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_out("t4 reset", 5'b00000, 32'd0, 1'b1);
        step();
        expect_out("t4 quiet", 5'b00000, 32'd0, 1'b1);
        pulse_start();
        expect_out("t4 newblock", 5'b11010, 32'd0, 1'b1);
        step();
        expect_out("t4 b10", 5'b10010, 32'd10, 1'b1);

        // success_i while base 20 is on the outputs.
        pulse_start();
        expect_out("t5 newblock", 5'b11010, 32'd0, 1'b1);
        step();
        step();
        expect_out("t5 b20", 5'b10010, 32'd20, 1'b1);
        success_i = 1'b1;
`ifdef NONCE_DISPATCHER_SUCCESS_ABORT_EN
        step();
        success_i = 1'b0;
        expect_out("t5 abort", 5'b00000, 32'd0, 1'b0);
        step();
        expect_out("t5 stays idle", 5'b00000, 32'd0, 1'b0);
`else
        sweep_rest("t5 ignore", 3);
        success_i = 1'b0;
`endif

        // Start coinciding with the last beat wins; exhausted stays 0.
        pulse_start();
        sweep_rest("t7 pre", 1);
        pulse_start();
        for (int k = 1; k <= 5; k++) step();
        step();
        expect_out("t7 last", 5'b10110, 32'd60, 1'b1);
        pulse_start();
        expect_out("t7 start wins", 5'b11010, 32'd0, 1'b1);

        // Start under hold is remembered until hold drops.
        start_i = 1'b1;
        hold_i  = 1'b1;
        step();
        start_i = 1'b0;
        expect_out("t8 pending", 5'b00010, 32'd0, 1'b0);
        step();
        expect_out("t8 still held", 5'b00010, 32'd0, 1'b0);
        hold_i = 1'b0;
        step();
        expect_out("t8 newblock", 5'b11010, 32'd0, 1'b1);
        sweep_rest("t8", 1);

        // 32-bit space: jump the frozen base close to 2^32 and run off the end.
        start32 = 1'b1;
        step();
        start32 = 1'b0;
        expect32("t6 newblock", 5'b11010, 32'd0);
        step();
        expect32("t6 b10", 5'b10010, 32'd10);
        hold32 = 1'b1;
        step();
        expect32("t6 held", 5'b00010, 32'd10);
        force dut32.u_cnt.base_r = 32'd4294967270;
        #1;
        release dut32.u_cnt.base_r;
        hold32 = 1'b0;
        step();
        expect32("t6 b-16", 5'b10010, 32'd4294967280);
        step();
        expect32("t6 last", 5'b10110, 32'd4294967290);
        step();
        check_val("t6 done flags32", 64'({valid32, newblock32, last32, busy32, exhausted32}),
                  64'(5'b00001));
        step();
        check_val("t6 no wrap", 64'({valid32, last32}), 64'(2'b00));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
- Issue side of the processor-array nonce protocol. Generates the valid/newblock beat stream that drives the hash processors.
- Each valid beat covers NUMPROCESSORS consecutive nonces: lane k on that beat tests nonce_base_o + k.
- The newblock beat carries base 0, and every later valid beat advances the base by NUMPROCESSORS. A downstream extractor can therefore rebuild the nonce from beat count plus processor index.
- Sits between the block-header loader and the processor array.

Parameters:
- NUMPROCESSORS, 10: lanes per beat; base increment per beat.
- NONCE_BITS, 32: width of the nonce space; the sweep covers 0 .. 2^NONCE_BITS-1; must be 1..32.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; new block header loaded, begin a sweep.
- hold_i  in  1  array backpressure; no beat issued while high.
- success_i  in  1  downstream found a winning nonce for the current block.
- valid_o  out  1  beat present this cycle.
- newblock_o  out  1  first beat of a block; only asserted with valid_o.
- nonce_base_o  out  32  base nonce of current beat; bits above NONCE_BITS are always 0.
- last_o  out  1  final beat of the sweep; only asserted with valid_o.
- busy_o  out  1  sweep in progress, or start pending.
- exhausted_o  out  1  sticky; full space swept without abort; cleared by start_i or rst.

Behaviour:
- Reset: rst sampled high gives, next cycle, valid_o=0, newblock_o=0, last_o=0, busy_o=0, exhausted_o=0, nonce_base_o=0, state IDLE, pending cleared. Applies mid-sweep: the sweep is dropped with no further beats.
- All outputs are registered.
- States: IDLE, FIRST, SWEEP.
- IDLE: valid_o=0. start_i moves to FIRST and clears exhausted_o.
- FIRST: when hold_i=0, issue the beat valid_o=1, newblock_o=1, base=0, then go to SWEEP. When hold_i=1, stay in FIRST with valid_o=0.
- SWEEP: when hold_i=0, issue valid_o=1, newblock_o=0, base = previous base + NUMPROCESSORS. When hold_i=1, valid_o=0 and base frozen.
- Latency: start_i at cycle N with hold_i=0 gives the newblock beat at N+1, and successive beats at N+2, N+3, ...
- Last-beat rule: a beat with base B is last when B + NUMPROCESSORS >= 2^NONCE_BITS. Compute in 33 bits; no wrap-around is ever issued.
  - last_o=1 on that beat. Next state is IDLE and exhausted_o=1.
  - If the newblock beat is also last (NUMPROCESSORS >= 2^NONCE_BITS), it carries both newblock_o and last_o.
- start_i in FIRST or SWEEP: preempts the sweep. The next issued beat is a newblock beat with base 0; no last_o is emitted for the abandoned sweep.
- start_i together with the last beat: start wins. State becomes FIRST, exhausted_o stays 0.
- start_i together with hold_i: the start is recorded and the newblock beat is issued on the first cycle hold_i is low.
- busy_o = 1 in FIRST and SWEEP; 0 in IDLE.
- success_i: handled only as described under Optional Feature; it never alters nonce_base_o sequencing except through abort.

Optional Feature:
- Macro: NONCE_DISPATCHER_SUCCESS_ABORT_EN.
- Defined: success_i=1 in SWEEP or FIRST moves to IDLE next cycle. No further beats are issued, exhausted_o stays 0. If start_i is high in the same cycle, start wins.
- Undefined: success_i is ignored and every sweep runs to exhaustion or preemption.

Decomposition:
- Shared package nonce_pkg:
  - nonce_t, a 32-bit logic typedef, also used by the extractor.
  - dispatch_state_t enum {IDLE, FIRST, SWEEP}.
  - Function next_base(base, step) returning a 33-bit sum.
- Sub-module: nonce_step_counter, a loadable accumulator with clear-to-0, enable, add-constant and 33-bit carry/limit compare output. The dispatcher instantiates one.

Test Plan:
1. NUMPROCESSORS=10, NONCE_BITS=6, start_i pulse at cycle 5, hold_i=0.
   - Newblock beat base 0 at cycle 6, then bases 10,20,30,40,50 at cycles 7-11.
   - Base 60 at cycle 12 with last_o=1; exhausted_o=1 and busy_o=0 from cycle 13.
2. Same config, hold_i high for cycles 8-9.
   - Bases 0,10 at cycles 6-7, valid_o=0 at 8-9, base 20 at cycle 10; no base skipped or repeated.
3. Start mid-sweep: second start_i while base 30 is issued.
   - Next beat has newblock_o=1 and base 0; the old sweep never shows last_o.
4. rst asserted while base 40 is issued.
   - All outputs 0 next cycle. A later start_i restarts cleanly from base 0.
5. With NONCE_DISPATCHER_SUCCESS_ABORT_EN, success_i at base 20.
   - No beat the following cycle; busy_o=0, exhausted_o=0.
   - Without the macro, the sweep continues to base 60 with last_o=1.
6. NUMPROCESSORS=10, NONCE_BITS=32, base preloaded near 2^32 via long run or force.
   - Last beat base 4294967290 with last_o=1; no beat with wrapped base follows.
